// File: rtl/operand_sequencer.sv
// operand_sequencer: collects two operand words over a valid/ready handshake
// (first word -> A, second word -> B), then holds en high for HOLD_CYCLES
// cycles so the downstream enable stage passes A/B to the ALU.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   data_in     operand word from the source
//   data_valid  data_in valid this cycle
//   data_ready  sequencer can accept data_in this cycle
//   abort       synchronous cancel of the current sequence
//   A, B        registered operands to the enable stage
//   en          registered enable to the enable stage
//   busy        high in any state other than IDLE
module operand_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             en,
  output logic             busy
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("operand_sequencer: HOLD_CYCLES must be in 1..255");
  end

  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD_B, ISSUE} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       started;   // keeps data_ready low until the first edge after reset release
  logic       xfer;

  always_comb begin
    state_nx   = state;
    data_ready = started && (state != ISSUE);
    busy       = (state != IDLE);
    xfer       = data_valid && data_ready && !abort;
    case (state)
      IDLE:    if (xfer) state_nx = LOAD_B;
      LOAD_B:  if (xfer) state_nx = ISSUE;
      ISSUE:   if (cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
      A       <= '0;
      B       <= '0;
      en      <= 1'b0;
      cnt     <= '0;
    end else begin
      started <= 1'b1;
      state   <= state_nx;
      if (abort) begin
        en  <= 1'b0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: if (xfer) A <= data_in;
          LOAD_B: if (xfer) begin
            B   <= data_in;
            en  <= 1'b1;
            cnt <= HOLD_M1;
          end
          ISSUE: begin
            if (cnt == '0) en <= 1'b0;
            else           cnt <= cnt - 8'd1;
          end
          default: en <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer: two instances (HOLD_CYCLES=1 and 3) share
// one stimulus stream; a transaction-level model predicts both every cycle,
// and directed sequences pin exact values by hand.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       abort = 1'b0;

  logic [3:0] a1, b1, a3, b3;
  logic       rdy1, en1, busy1, rdy3, en3, busy3;

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  operand_sequencer #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy1), .abort(abort), .A(a1), .B(b1), .en(en1), .busy(busy1));

  operand_sequencer #(.WIDTH(4), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy3), .abort(abort), .A(a3), .B(b3), .en(en3), .busy(busy3));

  // Model: per instance, whether A is held awaiting B, and how many en
  // cycles remain in the current issue window.
  int   hold_of [2] = '{1, 3};
  logic [3:0] m_a [2];
  logic [3:0] m_b [2];
  bit   m_have_a [2];
  int   m_remain [2];
  bit   m_started;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0;
      for (int k = 0; k < 2; k++) begin
        m_a[k] = '0; m_b[k] = '0; m_have_a[k] = 0; m_remain[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit ready;
        ready = m_started && (m_remain[k] == 0);
        if (abort) begin
          m_have_a[k] = 0;
          m_remain[k] = 0;
        end else if (m_remain[k] > 0) begin
          m_remain[k] = m_remain[k] - 1;
        end else if (data_valid && ready) begin
          if (!m_have_a[k]) begin
            m_a[k] = data_in; m_have_a[k] = 1;
          end else begin
            m_b[k] = data_in; m_have_a[k] = 0; m_remain[k] = hold_of[k];
          end
        end
      end
      m_started = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every cycle: compare both instances with the model, away from the clock edge.
  bit cmp_on = 0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m1.A",    32'(a1),    32'(m_a[0]));
      chk("m1.B",    32'(b1),    32'(m_b[0]));
      chk("m1.en",   32'(en1),   32'(m_remain[0] > 0));
      chk("m1.rdy",  32'(rdy1),  32'(m_started && m_remain[0] == 0));
      chk("m1.busy", 32'(busy1), 32'(m_have_a[0] || m_remain[0] > 0));
      chk("m3.A",    32'(a3),    32'(m_a[1]));
      chk("m3.B",    32'(b3),    32'(m_b[1]));
      chk("m3.en",   32'(en3),   32'(m_remain[1] > 0));
      chk("m3.rdy",  32'(rdy3),  32'(m_started && m_remain[1] == 0));
      chk("m3.busy", 32'(busy3), 32'(m_have_a[1] || m_remain[1] > 0));
    end
  end

  // Drive inputs for the next edge, then return 2 time units after that edge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic ab);
    data_valid = v; data_in = d; abort = ab;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1. Reset with data_valid high
    rst_n = 1'b0; data_valid = 1'b1; data_in = 4'h5;
    cmp_on = 1;
    @(posedge clk); @(posedge clk); #2;
    chk("rst.A", 32'(a1), 0); chk("rst.B", 32'(b1), 0);
    chk("rst.en", 32'(en1), 0); chk("rst.rdy", 32'(rdy1), 0);
    chk("rst.busy", 32'(busy1), 0);
    rst_n = 1'b1;
    #1 chk("rel.rdy_low", 32'(rdy1), 0);
    cyc(0, 4'h0, 0);
    chk("rel.rdy1", 32'(rdy1), 1); chk("rel.rdy3", 32'(rdy3), 1);

    // 2. Basic issue
    cyc(1, 4'b1010, 0);
    chk("t2.A", 32'(a1), 32'hA); chk("t2.busy", 32'(busy1), 1); chk("t2.en0", 32'(en1), 0);
    cyc(1, 4'b0101, 0);
    chk("t2.B", 32'(b1), 32'h5); chk("t2.en1", 32'(en1), 1); chk("t2.rdy0", 32'(rdy1), 0);
    chk("t2.en3", 32'(en3), 1);
    cyc(0, 4'h0, 0);
    chk("t2.en_off", 32'(en1), 0); chk("t2.rdy1", 32'(rdy1), 1);
    chk("t2.en3b", 32'(en3), 1);
    cyc(0, 4'h0, 0);
    chk("t2.en3c", 32'(en3), 1);
    cyc(0, 4'h0, 0);
    chk("t2.en3_off", 32'(en3), 0); chk("t2.rdy3", 32'(rdy3), 1);

    // 3. HOLD_CYCLES=3 with a third word held on data_in
    cyc(1, 4'hF, 0);
    cyc(1, 4'h1, 0);
    chk("t3.en", 32'(en3), 1); chk("t3.B", 32'(b3), 32'h1);
    cyc(1, 4'h7, 0);
    chk("t3.en_c2", 32'(en3), 1); chk("t3.rdy_c2", 32'(rdy3), 0); chk("t3.A_c2", 32'(a3), 32'hF);
    cyc(1, 4'h7, 0);
    chk("t3.en_c3", 32'(en3), 1); chk("t3.rdy_c3", 32'(rdy3), 0);
    cyc(1, 4'h7, 0);
    chk("t3.en_off", 32'(en3), 0); chk("t3.A_held", 32'(a3), 32'hF); chk("t3.rdy", 32'(rdy3), 1);
    cyc(1, 4'h7, 0);
    chk("t3.A_new", 32'(a3), 32'h7);
    cyc(0, 4'h0, 1);
    chk("t3.abort_idle", 32'(busy3), 0); chk("t3.abort_idle1", 32'(busy1), 0);

    // 4. Gaps between words
    cyc(1, 4'b0011, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'h0, 0);
      chk("t4.gap_en", 32'(en3), 0); chk("t4.gap_busy", 32'(busy3), 1);
    end
    cyc(1, 4'b1100, 0);
    chk("t4.B", 32'(b3), 32'hC); chk("t4.en", 32'(en3), 1); chk("t4.A", 32'(a3), 32'h3);
    for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0);

    // 5. Abort with a concurrent word, then abort during ISSUE
    cyc(1, 4'b0110, 0);
    chk("t5.A", 32'(a3), 32'h6);
    cyc(1, 4'b1001, 1);
    chk("t5.busy", 32'(busy3), 0); chk("t5.B", 32'(b3), 32'hC);
    chk("t5.en", 32'(en3), 0); chk("t5.A_keep", 32'(a3), 32'h6);
    cyc(0, 4'h0, 0);
    chk("t5.en_never", 32'(en3), 0);
    cyc(1, 4'h2, 0);
    cyc(1, 4'h4, 0);
    chk("t5.en_issue", 32'(en3), 1);
    cyc(0, 4'h0, 1);
    chk("t5.en_abort", 32'(en3), 0); chk("t5.rdy", 32'(rdy3), 1); chk("t5.B_keep", 32'(b3), 32'h4);

    // 6. Async reset during the second en cycle
    cyc(1, 4'h8, 0);
    cyc(1, 4'h9, 0);
    cyc(0, 4'h0, 0);
    chk("t6.en_pre", 32'(en3), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6.en", 32'(en3), 0); chk("t6.A", 32'(a3), 0); chk("t6.B", 32'(b3), 0);
    chk("t6.busy", 32'(busy3), 0); chk("t6.rdy", 32'(rdy3), 0);
    cyc(0, 4'h0, 0);
    rst_n = 1'b1;
    cyc(0, 4'h0, 0);

    // Randomized traffic checked by the per-cycle compare
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        cyc(1'($urandom), 4'($urandom), 0);
        rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 15) == 0));
    end

    cmp_on = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
